// File: rtl/bundle_tx.sv
// Transmit side of the some_prefix valid/ready bundle: emits a burst of
// num_beats beats with data lanes seed+idx, seed+idx+1, seed+idx+2.
module bundle_tx #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned GAP_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_beats,
  input  logic [DATA_W-1:0] seed,
  input  logic [GAP_W-1:0]  gap,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  beat_count,
  output logic              some_prefix_valid,
  input  logic              some_prefix_ready,
  output logic [DATA_W-1:0] some_prefix_bits_data_0,
  output logic [DATA_W-1:0] some_prefix_bits_data_1,
  output logic [DATA_W-1:0] some_prefix_bits_data_2
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t r_state, w_state_nx;

  logic [CNT_W-1:0]  r_num_beats, w_num_beats_nx;
  logic [DATA_W-1:0] r_seed, w_seed_nx;
  logic [GAP_W-1:0]  r_gap, w_gap_nx;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nx;
  logic [CNT_W-1:0]  r_idx, w_idx_nx;
  logic              r_abort_pend, w_abort_pend_nx;
  logic              r_valid, w_valid_nx;
  logic              r_busy, w_busy_nx;
  logic              r_done, w_done_nx;
  logic              r_aborted, w_aborted_nx;
  logic [CNT_W-1:0]  r_beat_count, w_beat_count_nx;
  logic [DATA_W-1:0] r_data0, r_data1, r_data2;
  logic [DATA_W-1:0] w_data0_nx, w_data1_nx, w_data2_nx;

  logic              w_hs;
  logic              w_last;
  logic              w_stop;
  logic [CNT_W-1:0]  w_next_idx;
  logic [DATA_W-1:0] w_next_base;
  logic [DATA_W-1:0] w_cur_base;

  assign w_hs        = r_valid & some_prefix_ready;
  assign w_last      = ((r_beat_count + CNT_W'(1)) == r_num_beats);
  // An abort arriving on the handshake edge itself still lets that beat finish.
  assign w_stop      = w_last | r_abort_pend | abort;
  assign w_next_idx  = r_idx + CNT_W'(1);
  assign w_next_base = r_seed + DATA_W'(w_next_idx);
  assign w_cur_base  = r_seed + DATA_W'(r_idx);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (start && (num_beats != '0)) w_state_nx = S_SEND;
      S_SEND: begin
        if (w_hs) begin
          if (w_stop)            w_state_nx = S_IDLE;
          else if (r_gap != '0)  w_state_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (abort)                          w_state_nx = S_IDLE;
        else if (r_gap_cnt == GAP_W'(1))    w_state_nx = S_SEND;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_num_beats_nx  = r_num_beats;
    w_seed_nx       = r_seed;
    w_gap_nx        = r_gap;
    w_gap_cnt_nx    = r_gap_cnt;
    w_idx_nx        = r_idx;
    w_abort_pend_nx = r_abort_pend;
    w_valid_nx      = r_valid;
    w_busy_nx       = r_busy;
    w_done_nx       = 1'b0;
    w_aborted_nx    = 1'b0;
    w_beat_count_nx = r_beat_count;
    w_data0_nx      = r_data0;
    w_data1_nx      = r_data1;
    w_data2_nx      = r_data2;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_beat_count_nx = '0;
          if (num_beats != '0) begin
            w_num_beats_nx  = num_beats;
            w_seed_nx       = seed;
            w_gap_nx        = gap;
            w_idx_nx        = '0;
            w_abort_pend_nx = 1'b0;
            w_valid_nx      = 1'b1;
            w_busy_nx       = 1'b1;
            w_data0_nx      = seed;
            w_data1_nx      = seed + DATA_W'(1);
            w_data2_nx      = seed + DATA_W'(2);
          end else begin
            w_done_nx = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (abort) w_abort_pend_nx = 1'b1;
        if (w_hs) begin
          w_beat_count_nx = r_beat_count + CNT_W'(1);
          if (w_stop) begin
            w_valid_nx      = 1'b0;
            w_busy_nx       = 1'b0;
            w_done_nx       = 1'b1;
            w_aborted_nx    = ~w_last;
            w_abort_pend_nx = 1'b0;
          end else begin
            w_idx_nx = w_next_idx;
            if (r_gap == '0) begin
              w_data0_nx = w_next_base;
              w_data1_nx = w_next_base + DATA_W'(1);
              w_data2_nx = w_next_base + DATA_W'(2);
            end else begin
              w_valid_nx   = 1'b0;
              w_gap_cnt_nx = r_gap;
            end
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          w_valid_nx      = 1'b0;
          w_busy_nx       = 1'b0;
          w_done_nx       = 1'b1;
          w_aborted_nx    = 1'b1;
          w_abort_pend_nx = 1'b0;
        end else if (r_gap_cnt == GAP_W'(1)) begin
          w_valid_nx = 1'b1;
          w_data0_nx = w_cur_base;
          w_data1_nx = w_cur_base + DATA_W'(1);
          w_data2_nx = w_cur_base + DATA_W'(2);
        end else begin
          w_gap_cnt_nx = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_valid_nx = 1'b0;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_num_beats  <= '0;
      r_seed       <= '0;
      r_gap        <= '0;
      r_gap_cnt    <= '0;
      r_idx        <= '0;
      r_abort_pend <= 1'b0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_beat_count <= '0;
      r_data0      <= '0;
      r_data1      <= '0;
      r_data2      <= '0;
    end else begin
      r_num_beats  <= w_num_beats_nx;
      r_seed       <= w_seed_nx;
      r_gap        <= w_gap_nx;
      r_gap_cnt    <= w_gap_cnt_nx;
      r_idx        <= w_idx_nx;
      r_abort_pend <= w_abort_pend_nx;
      r_valid      <= w_valid_nx;
      r_busy       <= w_busy_nx;
      r_done       <= w_done_nx;
      r_aborted    <= w_aborted_nx;
      r_beat_count <= w_beat_count_nx;
      r_data0      <= w_data0_nx;
      r_data1      <= w_data1_nx;
      r_data2      <= w_data2_nx;
    end
  end

  assign busy                    = r_busy;
  assign done                    = r_done;
  assign aborted                 = r_aborted;
  assign beat_count              = r_beat_count;
  assign some_prefix_valid       = r_valid;
  assign some_prefix_bits_data_0 = r_data0;
  assign some_prefix_bits_data_1 = r_data1;
  assign some_prefix_bits_data_2 = r_data2;

endmodule

// File: tb/tb_bundle_tx.sv
// Bench for bundle_tx: directed bursts plus randomized bursts scored against
// a burst-level model (beat k carries seed+k, gap idle cycles, done timing).
module tb_bundle_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, abort, ready;
  logic [7:0] num_beats, seed;
  logic [3:0] gap;
  logic       busy, done, aborted, valid;
  logic [7:0] beat_count, d0, d1, d2;

  int total = 0;
  int bad   = 0;

  bundle_tx #(.DATA_W(8), .CNT_W(8), .GAP_W(4)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .num_beats(num_beats), .seed(seed), .gap(gap),
    .busy(busy), .done(done), .aborted(aborted), .beat_count(beat_count),
    .some_prefix_valid(valid), .some_prefix_ready(ready),
    .some_prefix_bits_data_0(d0), .some_prefix_bits_data_1(d1),
    .some_prefix_bits_data_2(d2)
  );

  always #5 clock = ~clock;

  // Per-cycle capture of one burst, cycle 0 = first negedge after start is taken.
  logic       cv[256], cdone[256], cab[256], cbusy[256], chs[256];
  logic [7:0] cd0[256], cd1[256], cd2[256], cbc[256];
  int         ccount;
  int         cabort_c;
  bit         ctimeout;

  task automatic run(input int n, input logic [7:0] sd, input int g, input int pct,
                     input int hold, input int amode, input int aidx, input bit noise);
    int k;
    bit sent, got;
    @(negedge clock);
    start = 1'b1; abort = 1'b0; ready = 1'b0;
    num_beats = n[7:0]; seed = sd; gap = g[3:0];
    k = 0; sent = 0; got = 0; ccount = 0; cabort_c = -1;
    for (int c = 0; c < 256 && !got; c++) begin
      @(negedge clock);
      start = 1'b0;
      cv[c] = valid; cd0[c] = d0; cd1[c] = d1; cd2[c] = d2;
      cdone[c] = done; cab[c] = aborted; cbusy[c] = busy; cbc[c] = beat_count;
      chs[c] = 1'b0;
      ccount = c + 1;
      if (done) begin
        got = 1; ready = 1'b0; abort = 1'b0;
      end else begin
        ready = (c < hold) ? 1'b0 : ($urandom_range(1, 100) <= pct);
        abort = 1'b0;
        if (amode == 1 && !sent && valid && k == aidx) begin
          abort = 1'b1; ready = 1'b0; sent = 1; cabort_c = c;
        end
        if (amode == 2 && !sent && !valid && k == aidx + 1) begin
          abort = 1'b1; sent = 1; cabort_c = c;
        end
        if (noise && $urandom_range(0, 3) == 0) begin
          start = 1'b1; num_beats = 8'($urandom); seed = 8'($urandom); gap = 4'($urandom);
        end
        chs[c] = valid & ready;
        if (valid & ready) k++;
      end
    end
    ctimeout = !got;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
    num_beats = '0; seed = '0; gap = '0;
    repeat (2) @(negedge clock);
    total++;
    if ({valid, busy, done, aborted} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {valid, busy, done, aborted});
    end
    total++;
    if ({beat_count, d0, d1, d2} !== 32'h0) begin
      bad++; $display("FAIL reset_values got=%h exp=00000000", {beat_count, d0, d1, d2});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic;
    run(3, 8'h10, 0, 100, 0, 0, 0, 0);
    total++;
    if (ctimeout || ccount !== 4) begin
      bad++; $display("FAIL basic_len got=%0d exp=4", ccount);
    end
    for (int i = 0; i < 3; i++) begin
      logic [23:0] e;
      e = {8'(8'h10 + i), 8'(8'h11 + i), 8'(8'h12 + i)};
      total++;
      if ({cv[i], cd0[i], cd1[i], cd2[i]} !== {1'b1, e}) begin
        bad++; $display("FAIL basic_beat%0d got=%h exp=%h", i, {cv[i], cd0[i], cd1[i], cd2[i]}, {1'b1, e});
      end
    end
    total++;
    if ({cdone[3], cab[3], cv[3], cbc[3]} !== {3'b100, 8'd3}) begin
      bad++; $display("FAIL basic_done got=%b/%0d exp=100/3", {cdone[3], cab[3], cv[3]}, cbc[3]);
    end
  endtask

  task automatic test_backpressure;
    run(2, 8'h10, 0, 100, 4, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({cv[i], cd0[i], cd1[i], cd2[i]} !== {1'b1, 24'h10_11_12}) begin
        bad++; $display("FAIL bp_hold%0d got=%h exp=1101112", i, {cv[i], cd0[i], cd1[i], cd2[i]});
      end
    end
    total++;
    if ({chs[3], chs[4]} !== 2'b01) begin
      bad++; $display("FAIL bp_accept got=%b exp=01", {chs[3], chs[4]});
    end
    total++;
    if (ctimeout || ccount !== 7 || {cv[5], cd0[5], cdone[6], cbc[6]} !== {1'b1, 8'h11, 1'b1, 8'd2}) begin
      bad++; $display("FAIL bp_end got=len%0d v%b d%h done%b bc%0d exp=len7 v1 d11 done1 bc2",
                      ccount, cv[5], cd0[5], cdone[6], cbc[6]);
    end
  endtask

  task automatic test_gap;
    logic [6:0] pat, got;
    pat = 7'b1001001;
    run(3, 8'h10, 2, 100, 0, 0, 0, 0);
    got = '0;
    for (int i = 0; i < 7; i++) got[i] = cv[i];
    total++;
    if (got !== pat) begin
      bad++; $display("FAIL gap_pattern got=%b exp=%b", got, pat);
    end
    total++;
    if (ctimeout || ccount !== 8 || {cdone[7], cd0[3], cd0[6]} !== {1'b1, 8'h11, 8'h12}) begin
      bad++; $display("FAIL gap_end got=len%0d done%b d%h/%h exp=len8 done1 d11/12",
                      ccount, cdone[7], cd0[3], cd0[6]);
    end
  endtask

  task automatic test_wrap;
    run(3, 8'hFE, 0, 100, 0, 0, 0, 0);
    total++;
    if ({cd0[0], cd0[1], cd0[2]} !== 24'hFE_FF_00) begin
      bad++; $display("FAIL wrap_d0 got=%h exp=feff00", {cd0[0], cd0[1], cd0[2]});
    end
    total++;
    if ({cd2[0], cd2[1], cd2[2], cd1[1]} !== 32'h00_01_02_00) begin
      bad++; $display("FAIL wrap_d2 got=%h exp=00010200", {cd2[0], cd2[1], cd2[2], cd1[1]});
    end
  endtask

  task automatic test_abort;
    run(5, 8'h10, 0, 100, 0, 1, 1, 0);
    total++;
    if (ctimeout || ccount !== 4 || {chs[2], cd0[2]} !== {1'b1, 8'h11}) begin
      bad++; $display("FAIL abort_beat got=len%0d hs%b d%h exp=len4 hs1 d11", ccount, chs[2], cd0[2]);
    end
    total++;
    if ({cdone[3], cab[3], cbc[3]} !== {2'b11, 8'd2}) begin
      bad++; $display("FAIL abort_done got=%b/%0d exp=11/2", {cdone[3], cab[3]}, cbc[3]);
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if ({valid, done, aborted, busy} !== 4'b0000) begin
        bad++; $display("FAIL abort_quiet%0d got=%b exp=0000", i, {valid, done, aborted, busy});
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit saw;
    @(negedge clock);
    start = 1'b1; num_beats = 8'd6; seed = 8'h20; gap = 4'd0; ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({valid, busy, done, beat_count} !== 11'h0) begin
      bad++; $display("FAIL rstmid_async got=%b/%0d exp=000/0", {valid, busy, done}, beat_count);
    end
    @(negedge clock);
    reset = 1'b0;
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (done || valid) saw = 1;
    end
    total++;
    if (saw !== 1'b0) begin
      bad++; $display("FAIL rstmid_quiet got=%b exp=0", saw);
    end
    run(3, 8'h40, 0, 100, 0, 0, 0, 0);
    total++;
    if (ctimeout || ccount !== 4 || {cd0[0], cd1[0], cd2[0], cd0[2], cbc[3]} !== 40'h40_41_42_42_03) begin
      bad++; $display("FAIL rstmid_restart got=len%0d %h %h %h %h bc%0d exp=len4 40 41 42 42 bc3",
                      ccount, cd0[0], cd1[0], cd2[0], cd0[2], cbc[3]);
    end
  endtask

  task automatic test_zero_and_idle;
    run(0, 8'h33, 1, 100, 0, 0, 0, 0);
    total++;
    if (ctimeout || ccount !== 1 || {cdone[0], cv[0], cbusy[0], cab[0]} !== 4'b1000) begin
      bad++; $display("FAIL zero_beats got=len%0d %b exp=len1 1000", ccount, {cdone[0], cv[0], cbusy[0], cab[0]});
    end
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    total++;
    if ({done, aborted, valid} !== 3'b000) begin
      bad++; $display("FAIL idle_abort got=%b exp=000", {done, aborted, valid});
    end
    start = 1'b1; abort = 1'b1; num_beats = 8'd1; seed = 8'h55; gap = 4'd0;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    total++;
    if ({valid, busy, d0} !== {2'b11, 8'h55}) begin
      bad++; $display("FAIL start_wins got=%b d%h exp=11 d55", {valid, busy}, d0);
    end
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    total++;
    if ({done, aborted, beat_count} !== {2'b10, 8'd1}) begin
      bad++; $display("FAIL start_wins_end got=%b/%0d exp=10/1", {done, aborted}, beat_count);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      int n, g, pct, amode, aidx, exp_beats, exp_dc, k, idle, last_hs, bad_busy, dc;
      bit noise, pend, exp_ab;
      logic [7:0] sd;
      logic [23:0] e;
      n = $urandom_range(1, 12); g = $urandom_range(0, 3); pct = $urandom_range(30, 100);
      sd = 8'($urandom); noise = 1'($urandom_range(0, 1));
      amode = $urandom_range(0, 2); aidx = 0;
      if (n < 2 || (amode == 2 && g == 0)) amode = 0;
      if (amode != 0) aidx = $urandom_range(0, n - 2);
      exp_beats = (amode == 0) ? n : aidx + 1;
      exp_ab = (amode != 0);
      run(n, sd, g, pct, 0, amode, aidx, noise);
      total++;
      if (ctimeout) begin
        bad++; $display("FAIL rnd_timeout it=%0d got=no_done exp=done", it);
        continue;
      end
      dc = ccount - 1;
      k = 0; idle = 0; last_hs = -1; pend = 0; bad_busy = 0;
      for (int c = 0; c < dc; c++) begin
        if (!cbusy[c] || cdone[c] || cab[c]) bad_busy++;
        if (c > 0 && !cv[c] && cv[c-1] && !chs[c-1]) begin
          total++; bad++; $display("FAIL rnd_valid_drop it=%0d c=%0d got=0 exp=1", it, c);
        end
        if (cv[c]) begin
          e = {8'(sd + 8'(k)), 8'(sd + 8'(k + 1)), 8'(sd + 8'(k + 2))};
          total++;
          if ({cd0[c], cd1[c], cd2[c]} !== e) begin
            bad++; $display("FAIL rnd_data it=%0d beat=%0d got=%h exp=%h", it, k, {cd0[c], cd1[c], cd2[c]}, e);
          end
          if (pend) begin
            total++;
            if (idle !== g) begin
              bad++; $display("FAIL rnd_gap it=%0d beat=%0d got=%0d exp=%0d", it, k, idle, g);
            end
            pend = 0;
          end
          if (chs[c]) begin k++; last_hs = c; idle = 0; pend = 1; end
        end else begin
          idle++;
        end
      end
      total++;
      if (bad_busy !== 0) begin
        bad++; $display("FAIL rnd_busy it=%0d got=%0d exp=0", it, bad_busy);
      end
      exp_dc = (amode == 2) ? cabort_c + 1 : last_hs + 1;
      total++;
      if (k !== exp_beats || dc !== exp_dc) begin
        bad++; $display("FAIL rnd_count it=%0d got=beats%0d dc%0d exp=beats%0d dc%0d", it, k, dc, exp_beats, exp_dc);
      end
      total++;
      if ({cab[dc], cbusy[dc], cv[dc], cbc[dc]} !== {exp_ab, 2'b00, 8'(exp_beats)}) begin
        bad++; $display("FAIL rnd_end it=%0d got=%b/%0d exp=%b00/%0d", it, {cab[dc], cbusy[dc], cv[dc]}, cbc[dc], exp_ab, exp_beats);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_gap;
    test_wrap;
    test_abort;
    test_reset_mid;
    test_zero_and_idle;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
